// File: rtl/tpu_ctrl_pkg.sv
// ============================================================================
// tpu_ctrl_pkg : shared systolic-array control types (state codes, address width)
// Revision     : 1.0
// ============================================================================
`default_nettype none

package tpu_ctrl_pkg;

   localparam int ADDR_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } wr_state_t;

   // Row addresses wrap modulo 2**ADDR_W by construction.
   function automatic logic [ADDR_W-1:0] row_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] offset);
      return base + offset;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wr_control_if.sv
// ============================================================================
// wr_control_if : start/base request and per-column write bus of wr_control
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface wr_control_if
   import tpu_ctrl_pkg::*;
#(
   parameter int width_height = 16
);
   localparam int data_width = width_height * ADDR_W;

   logic                    active;
   logic [ADDR_W-1:0]       base_addr;
   logic [width_height-1:0] wr_en;
   logic [data_width-1:0]   wr_addr;
   logic                    busy;
   logic                    done;

   modport master (
      output active,
      output base_addr,
      input  wr_en,
      input  wr_addr,
      input  busy,
      input  done
   );

   modport slave (
      input  active,
      input  base_addr,
      output wr_en,
      output wr_addr,
      output busy,
      output done
   );

endinterface

`default_nettype wire

// File: rtl/col_addr_gen.sv
// ============================================================================
// col_addr_gen : registered row address for one output column
// Revision     : 1.0
// ============================================================================
`default_nettype none

module col_addr_gen
   import tpu_ctrl_pkg::*;
#(
   parameter int COL     = 0,
   parameter int COUNT_W = 6
) (
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic               en_next,
   input  wire logic [ADDR_W-1:0]  base,
   input  wire logic [COUNT_W-1:0] count_next,
   output logic      [ADDR_W-1:0]  addr
);

   logic [ADDR_W-1:0] w_offset;

   // Column COL lags column 0 by COL cycles: row = base + (k - 1 - COL).
   always_comb begin
      w_offset = ADDR_W'(count_next) - ADDR_W'(COL + 1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr <= '0;
      end else if (en_next) begin
         addr <= row_addr(base, w_offset);
      end else begin
         addr <= '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/wr_control.sv
// ============================================================================
// wr_control : staggered per-column write enables/addresses for one W x W tile
// Revision   : 1.0
// ============================================================================
`default_nettype none

module wr_control
   import tpu_ctrl_pkg::*;
#(
   parameter int width_height = 16
) (
   input  wire logic   clk,
   input  wire logic   reset,
   wr_control_if.slave bus
);

   localparam int W           = width_height;
   localparam int data_width  = W * ADDR_W;
   localparam int count_width = $clog2(2 * W) + 1;

   localparam logic [count_width-1:0] c_last     = count_width'(2 * W - 1);
   localparam logic [count_width-1:0] c_fill_end = count_width'(W);

   wr_state_t              r_state;
   logic [count_width-1:0] r_count;
   logic [ADDR_W-1:0]      r_base;
   logic [W-1:0]           r_en;
   logic                   r_busy;
   logic                   r_done;
   logic [data_width-1:0]  w_addr;

   logic                   w_start;
   logic                   w_last;
   logic                   w_insert;
   logic [W-1:0]           w_en_next;
   logic [count_width-1:0] w_count_next;
   logic [ADDR_W-1:0]      w_base_sel;

   // Next-cycle enable/count/base are shared by the FSM and the column address registers.
   always_comb begin
      w_start    = (r_state == IDLE) && bus.active;
      w_last     = ((r_state == FILL) || (r_state == DRAIN)) && (r_count == c_last);
      w_insert   = w_start || ((r_state == FILL) && (r_count < c_fill_end));
      w_en_next  = (r_en << 1) | W'(w_insert);
      w_base_sel = w_start ? bus.base_addr : r_base;
      if (w_start) begin
         w_count_next = count_width'(1);
      end else if (((r_state == FILL) || (r_state == DRAIN)) && !w_last) begin
         w_count_next = r_count + count_width'(1);
      end else begin
         w_count_next = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_base  <= '0;
         r_en    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_count <= w_count_next;
         r_en    <= w_en_next;
         case (r_state)
            IDLE: begin
               if (bus.active) begin
                  r_base  <= bus.base_addr;
                  r_busy  <= 1'b1;
                  r_state <= FILL;
               end
            end
            FILL: begin
               if (w_last) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= FINISH;
               end else if (r_count == c_fill_end) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_last) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= FINISH;
               end
            end
            FINISH: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < W; i++) begin : g_col
      col_addr_gen #(
         .COL     (i),
         .COUNT_W (count_width)
      ) u_col (
         .clk        (clk),
         .reset      (reset),
         .en_next    (w_en_next[i]),
         .base       (w_base_sel),
         .count_next (w_count_next),
         .addr       (w_addr[i*ADDR_W +: ADDR_W])
      );
   end

   assign bus.wr_en   = r_en;
   assign bus.wr_addr = w_addr;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_wr_control.sv
// ============================================================================
// tb_wr_control : self-checking bench for wr_control (W=16 and W=4 instances)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_wr_control;

   localparam int W16 = 16;
   localparam int W4  = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   wr_control_if #(.width_height(W16)) bus16 ();
   wr_control_if #(.width_height(W4))  bus4 ();

   wr_control #(.width_height(W16)) u_dut16 (.clk(clk), .reset(rst_n), .bus(bus16));
   wr_control #(.width_height(W4))  u_dut4  (.clk(clk), .reset(rst_n), .bus(bus4));

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference for the W=16 instance: k = edges since the start edge (0 = idle).
   int         m_k;
   logic [7:0] m_base;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_k    <= 0;
         m_base <= '0;
      end else if (m_k == 0 || m_k == 2*W16 + 1) begin
         if (bus16.active) begin
            m_k    <= 1;
            m_base <= bus16.base_addr;
         end else begin
            m_k <= 0;
         end
      end else begin
         m_k <= m_k + 1;
      end
   end

   function automatic void model_out(input int k, input logic [7:0] b,
                                     output logic [15:0] en, output logic [127:0] addr,
                                     output logic busy, output logic done);
      en   = '0;
      addr = '0;
      busy = (k >= 1) && (k <= 2*W16 - 1);
      done = (k == 2*W16);
      for (int i = 0; i < W16; i++) begin
         if (busy && i >= k - W16 && i <= k - 1) begin
            en[i]         = 1'b1;
            addr[8*i +: 8] = b + 8'(k - 1 - i);
         end
      end
   endfunction

   bit chk_en     = 1'b0;
   int tiles_done = 0;
   int hits [16][256];

   always @(negedge clk) begin
      logic [15:0]  e_en;
      logic [127:0] e_addr;
      logic         e_busy, e_done;
      int           bad, total;
      if (chk_en) begin
         model_out(m_k, m_base, e_en, e_addr, e_busy, e_done);
         check("rand_outputs",
               256'({bus16.wr_en, bus16.wr_addr, bus16.busy, bus16.done}),
               256'({e_en, e_addr, e_busy, e_done}));
         if (m_k == 1) begin
            for (int i = 0; i < 16; i++)
               for (int r = 0; r < 256; r++) hits[i][r] = 0;
         end
         for (int i = 0; i < 16; i++)
            if (bus16.wr_en[i]) hits[i][bus16.wr_addr[8*i +: 8]]++;
         if (m_k == 2*W16) begin
            bad   = 0;
            total = 0;
            for (int i = 0; i < 16; i++) begin
               for (int j = 0; j < 16; j++)
                  if (hits[i][8'(m_base + 8'(j))] != 1) bad++;
               for (int r = 0; r < 256; r++) total += hits[i][r];
            end
            check("scoreboard_tile", 256'({bad, total}), 256'({32'd0, 32'd256}));
            tiles_done++;
         end
      end
   end

   typedef struct {
      logic        active;
      logic [7:0]  base;
      logic [3:0]  en;
      logic [31:0] addr;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t vecs [21];

   task automatic setv(input int n, input logic a, input logic [7:0] b, input logic [3:0] e,
                       input logic [31:0] ad, input logic bs, input logic d);
      vecs[n] = '{a, b, e, ad, bs, d};
   endtask

   initial begin
      int          ones, dones;
      logic        done_k32;
      // Tile A: base 0xFE wraps, base_addr changed mid-tile; tile B: active held high.
      setv( 0, 1'b1, 8'hFE, 4'h1, 32'h000000FE, 1'b1, 1'b0);
      setv( 1, 1'b0, 8'hFE, 4'h3, 32'h0000FEFF, 1'b1, 1'b0);
      setv( 2, 1'b0, 8'h10, 4'h7, 32'h00FEFF00, 1'b1, 1'b0);
      setv( 3, 1'b0, 8'h10, 4'hF, 32'hFEFF0001, 1'b1, 1'b0);
      setv( 4, 1'b0, 8'h10, 4'hE, 32'hFF000100, 1'b1, 1'b0);
      setv( 5, 1'b0, 8'h10, 4'hC, 32'h00010000, 1'b1, 1'b0);
      setv( 6, 1'b0, 8'h10, 4'h8, 32'h01000000, 1'b1, 1'b0);
      setv( 7, 1'b0, 8'h10, 4'h0, 32'h00000000, 1'b0, 1'b1);
      setv( 8, 1'b0, 8'h10, 4'h0, 32'h00000000, 1'b0, 1'b0);
      setv( 9, 1'b0, 8'h10, 4'h0, 32'h00000000, 1'b0, 1'b0);
      setv(10, 1'b1, 8'h10, 4'h1, 32'h00000010, 1'b1, 1'b0);
      setv(11, 1'b1, 8'h10, 4'h3, 32'h00001011, 1'b1, 1'b0);
      setv(12, 1'b1, 8'h10, 4'h7, 32'h00101112, 1'b1, 1'b0);
      setv(13, 1'b1, 8'h10, 4'hF, 32'h10111213, 1'b1, 1'b0);
      setv(14, 1'b1, 8'h10, 4'hE, 32'h11121300, 1'b1, 1'b0);
      setv(15, 1'b1, 8'h10, 4'hC, 32'h12130000, 1'b1, 1'b0);
      setv(16, 1'b1, 8'h10, 4'h8, 32'h13000000, 1'b1, 1'b0);
      setv(17, 1'b1, 8'h10, 4'h0, 32'h00000000, 1'b0, 1'b1);
      setv(18, 1'b1, 8'h10, 4'h0, 32'h00000000, 1'b0, 1'b0);
      setv(19, 1'b1, 8'h10, 4'h1, 32'h00000010, 1'b1, 1'b0);
      setv(20, 1'b0, 8'h10, 4'h3, 32'h00001011, 1'b1, 1'b0);

      rst_n           = 1'b0;
      bus16.active    = 1'b0;
      bus16.base_addr = '0;
      bus4.active     = 1'b0;
      bus4.base_addr  = '0;

      repeat (3) begin
         @(negedge clk);
         check("reset_state",
               256'({bus16.wr_en, bus16.wr_addr, bus16.busy, bus16.done}), 256'(0));
      end
      rst_n = 1'b1;
      repeat (10) begin
         step();
         check("idle_outputs",
               256'({bus16.wr_en, bus16.wr_addr, bus16.busy, bus16.done}), 256'(0));
      end

      for (int n = 0; n < 21; n++) begin
         bus4.active    = vecs[n].active;
         bus4.base_addr = vecs[n].base;
         step();
         check($sformatf("w4_vec%0d", n),
               256'({bus4.wr_en, bus4.wr_addr, bus4.busy, bus4.done}),
               256'({vecs[n].en, vecs[n].addr, vecs[n].busy, vecs[n].done}));
      end
      bus4.active = 1'b0;

      // Nominal W=16 tile at base 0.
      ones            = 0;
      dones           = 0;
      done_k32        = 1'b0;
      bus16.active    = 1'b1;
      bus16.base_addr = 8'h00;
      for (int k = 1; k <= 33; k++) begin
         step();
         bus16.active = 1'b0;
         ones  += $countones(bus16.wr_en);
         dones += int'(bus16.done);
         if (k == 1)
            check("nom_k1", 256'({bus16.wr_en, bus16.wr_addr[7:0], bus16.busy}),
                  256'({16'h0001, 8'h00, 1'b1}));
         if (k == 16)
            check("nom_k16", 256'({bus16.wr_en, bus16.wr_addr[7:0], bus16.wr_addr[127:120]}),
                  256'({16'hFFFF, 8'h0F, 8'h00}));
         if (k == 31)
            check("nom_k31", 256'({bus16.wr_en, bus16.wr_addr[127:120], bus16.busy}),
                  256'({16'h8000, 8'h0F, 1'b1}));
         if (k == 32) done_k32 = bus16.done;
      end
      check("nom_done_k32", 256'(done_k32), 256'(1));
      check("nom_done_count", 256'(dones), 256'(1));
      check("nom_enable_bits", 256'(ones), 256'(256));

      // Asynchronous reset mid-tile.
      bus16.active    = 1'b1;
      bus16.base_addr = 8'h40;
      step();
      bus16.active = 1'b0;
      repeat (8) step();
      check("ar_k9", 256'(bus16.wr_en), 256'(16'h01FF));
      #2 rst_n = 1'b0;
      #1 check("ar_async_clear",
               256'({bus16.wr_en, bus16.wr_addr, bus16.busy, bus16.done}), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         step();
         check("ar_no_done",
               256'({bus16.wr_en, bus16.wr_addr, bus16.busy, bus16.done}), 256'(0));
      end
      bus16.active = 1'b1;
      step();
      bus16.active = 1'b0;
      check("ar_restart", 256'({bus16.wr_en, bus16.wr_addr[7:0], bus16.busy}),
            256'({16'h0001, 8'h40, 1'b1}));
      repeat (33) step();

      // Random bases and back-to-back tiles against the reference model.
      chk_en = 1'b1;
      for (int t = 0; t < 400; t++) begin
         bus16.active    = ($urandom_range(0, 3) == 0);
         bus16.base_addr = 8'($urandom);
         step();
      end
      chk_en = 1'b0;
      check("tiles_completed", 256'(tiles_done >= 4), 256'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
